hv_adc_conv_ctrl: RTL

//  Conversion sequencer for the two HV ADC channels; sits in hv_top ahead of hv_adc_sample.
//  A frame timer issues a start-of-conversion (SOC) pulse to ADC1, then to ADC2.

---
 rtl/hv_adc_pkg.sv | 28 ++
 rtl/gnrl_sync.sv | 30 +++
 rtl/hv_adc_conv_cnt.sv | 35 +++
 rtl/hv_adc_conv_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hv_adc_pkg.sv
//------------------------------------------------------------------------------
// hv_adc_pkg : shared state encoding and timing defaults for the HV ADC sequencer
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hv_adc_pkg;

  localparam int ADC_DW          = 12;
  localparam int PERIOD_CYC_DEF  = 1000;
  localparam int START_CYC_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOC1  = 3'd1,
    WAIT1 = 3'd2,
    SOC2  = 3'd3,
    WAIT2 = 3'd4
  } adc_conv_st_e;

  function automatic int cnt_width(input int period, input int timeout);
    return $clog2(((period > timeout) ? period : timeout) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gnrl_sync.sv
//------------------------------------------------------------------------------
// gnrl_sync : two-flop synchroniser for asynchronous level inputs
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gnrl_sync #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hv_adc_conv_cnt.sv
//------------------------------------------------------------------------------
// hv_adc_conv_cnt : loadable down-counter timing SOC width and WAIT timeout
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hv_adc_conv_cnt #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [DW-1:0] cnt;

  // Saturates at zero so a late decrement never wraps into a long count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hv_adc_conv_ctrl.sv
//------------------------------------------------------------------------------
// hv_adc_conv_ctrl : serialised SOC/ready sequencer for the two HV ADC channels
// Revision 1.0 - initial release; WAIT timeout enabled by macro HV_ADC_TMO_EN
//------------------------------------------------------------------------------
`default_nettype none

module hv_adc_conv_ctrl
  import hv_adc_pkg::*;
#(
  parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int START_CYC   = START_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_adc_en,
  input  logic i_adc1_chn_en,
  input  logic i_adc2_chn_en,
  input  logic i_ang_dgt_adc1_rdy,
  input  logic i_ang_dgt_adc2_rdy,
  input  logic i_tmo_clr,
  output logic o_dgt_ang_adc1_start,
  output logic o_dgt_ang_adc2_start,
  output logic o_adc1_done,
  output logic o_adc2_done,
  output logic o_adc_busy,
  output logic o_frm_miss,
  output logic o_adc1_tmo,
  output logic o_adc2_tmo
);

  localparam int CNT_DW = cnt_width(PERIOD_CYC, TIMEOUT_CYC);
  localparam logic [CNT_DW-1:0] SOC_LOAD = CNT_DW'(START_CYC - 1);
`ifdef HV_ADC_TMO_EN
  localparam logic [CNT_DW-1:0] WAIT_LOAD = CNT_DW'(TIMEOUT_CYC - 1);
`endif

  adc_conv_st_e      state;
  adc_conv_st_e      state_nxt;
  logic [1:0]        rdy_in;
  logic [1:0]        rdy_s;
  logic [1:0]        rdy_s_ff;
  logic [1:0]        rdy_rise;
  logic [CNT_DW-1:0] frm_cnt;
  logic              tick;
  logic              cnt_load;
  logic [CNT_DW-1:0] cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              wait_exit;
  logic [1:0]        done_set;
`ifdef HV_ADC_TMO_EN
  logic [1:0]        tmo_set;
`endif

  assign rdy_in = {i_ang_dgt_adc2_rdy, i_ang_dgt_adc1_rdy};

  for (genvar g = 0; g < 2; g++) begin : g_rdy_sync
    gnrl_sync #(
      .DW (1)
    ) u_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .d     (rdy_in[g]),
      .q     (rdy_s[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_s_ff <= '0;
    end else begin
      rdy_s_ff <= rdy_s;
    end
  end

  assign rdy_rise = rdy_s & ~rdy_s_ff;

  // Frame timer is parked at zero while scheduling is disabled, so the first
  // frame after enable always lands a full period later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frm_cnt <= '0;
    end else if (!i_adc_en || (frm_cnt == CNT_DW'(PERIOD_CYC - 1))) begin
      frm_cnt <= '0;
    end else begin
      frm_cnt <= frm_cnt + CNT_DW'(1);
    end
  end

  assign tick = (frm_cnt == CNT_DW'(PERIOD_CYC - 1));

  hv_adc_conv_cnt #(
    .DW (CNT_DW)
  ) u_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    wait_exit    = 1'b0;
    done_set     = '0;
`ifdef HV_ADC_TMO_EN
    tmo_set      = '0;
`endif
    case (state)
      IDLE: begin
        if (tick) begin
          if (i_adc1_chn_en) begin
            state_nxt    = SOC1;
            cnt_load     = 1'b1;
            cnt_load_val = SOC_LOAD;
          end else if (i_adc2_chn_en) begin
            state_nxt    = SOC2;
            cnt_load     = 1'b1;
            cnt_load_val = SOC_LOAD;
          end
        end
      end
      SOC1: begin
        if (cnt_zero) begin
          state_nxt = WAIT1;
`ifdef HV_ADC_TMO_EN
          cnt_load     = 1'b1;
          cnt_load_val = WAIT_LOAD;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT1: begin
        if (rdy_rise[0]) begin
          done_set[0] = 1'b1;
          wait_exit   = 1'b1;
`ifdef HV_ADC_TMO_EN
        end else if (cnt_zero) begin
          tmo_set[0] = 1'b1;
          wait_exit  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
        // A dropped enable lets the current channel finish but starts no other.
        if (wait_exit) begin
          if (i_adc2_chn_en && i_adc_en) begin
            state_nxt    = SOC2;
            cnt_load     = 1'b1;
            cnt_load_val = SOC_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SOC2: begin
        if (cnt_zero) begin
          state_nxt = WAIT2;
`ifdef HV_ADC_TMO_EN
          cnt_load     = 1'b1;
          cnt_load_val = WAIT_LOAD;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT2: begin
        if (rdy_rise[1]) begin
          done_set[1] = 1'b1;
          state_nxt   = IDLE;
`ifdef HV_ADC_TMO_EN
        end else if (cnt_zero) begin
          tmo_set[1] = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dgt_ang_adc1_start <= 1'b0;
      o_dgt_ang_adc2_start <= 1'b0;
      o_adc1_done          <= 1'b0;
      o_adc2_done          <= 1'b0;
      o_frm_miss           <= 1'b0;
    end else begin
      o_dgt_ang_adc1_start <= (state_nxt == SOC1);
      o_dgt_ang_adc2_start <= (state_nxt == SOC2);
      o_adc1_done          <= done_set[0];
      o_adc2_done          <= done_set[1];
      o_frm_miss           <= tick && (state != IDLE);
    end
  end

  assign o_adc_busy = (state != IDLE);

`ifdef HV_ADC_TMO_EN
  // Sticky flags; a new timeout in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_adc1_tmo <= 1'b0;
      o_adc2_tmo <= 1'b0;
    end else begin
      o_adc1_tmo <= tmo_set[0] | (o_adc1_tmo & ~i_tmo_clr);
      o_adc2_tmo <= tmo_set[1] | (o_adc2_tmo & ~i_tmo_clr);
    end
  end
`else
  logic unused_tmo_clr;
  assign unused_tmo_clr = i_tmo_clr;
  assign o_adc1_tmo     = 1'b0;
  assign o_adc2_tmo     = 1'b0;
`endif

endmodule

`default_nettype wire
